// File: rtl/fast_square_pkg.sv
// Shared definitions for the fast-square sweep controller: default widths and
// the sweep state encoding.
package fast_square_pkg;

  localparam int SW_DEFAULT = 8;   // step-count width
  localparam int CW_DEFAULT = 16;  // settle/record counter width

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_RECORD = 3'd2,
    ST_STEP   = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

endpackage

// File: rtl/fast_square_strobe_counter.sv
// Strobe counter shared by the SETTLE and RECORD phases. It counts enabled
// strobes, saturates instead of wrapping, and flags the strobe that brings the
// count up to len. A zero len never produces a terminal flag; the caller
// handles that case on its own.
module fast_square_strobe_counter
  import fast_square_pkg::*;
#(
  parameter int CW = CW_DEFAULT
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          clr,
  input  logic          en,
  input  logic [CW-1:0] len,
  output logic          term
);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Next count: clear wins, otherwise count enabled strobes up to saturation.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != {CW{1'b1}})) begin
      count_d = count_q + CW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Terminal flag on the strobe cycle that would make the count equal len.
  assign term = en && (len != '0) && (count_q == (len - CW'(1)));

endmodule

// File: rtl/fast_square_sweep_ctrl.sv
// Frequency-sweep sequencer: for each frequency point it discards settle_len
// decimated strobes, records record_len strobes, then pulses freq_step to move
// to the next point. Configuration is captured at start so the sweep is
// immune to mid-sweep input changes. abort returns to IDLE without a done.
module fast_square_sweep_ctrl
  import fast_square_pkg::*;
#(
  parameter int SW = SW_DEFAULT,
  parameter int CW = CW_DEFAULT
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          start,
  input  logic          abort,
  input  logic          strobe_in,
  input  logic [SW-1:0] num_steps,
  input  logic [CW-1:0] settle_len,
  input  logic [CW-1:0] record_len,
  output logic          freq_step,
  output logic          record,
  output logic          sample_valid,
  output logic          busy,
  output logic          done,
  output logic [SW-1:0] step_index
);

  state_e        state_q, state_d;
  logic [SW-1:0] step_q, step_d;
  logic [SW-1:0] num_steps_q, num_steps_d;
  logic [CW-1:0] settle_len_q, settle_len_d;
  logic [CW-1:0] record_len_q, record_len_d;

  logic          cnt_clr;
  logic          cnt_en;
  logic          cnt_term;
  logic [CW-1:0] cnt_len;
  logic          in_count_state;
  logic          last_step;

  assign in_count_state = (state_q == ST_SETTLE) || (state_q == ST_RECORD);
  assign cnt_en         = strobe_in && in_count_state;
  assign cnt_len        = (state_q == ST_RECORD) ? record_len_q : settle_len_q;
  assign last_step      = (step_q == (num_steps_q - SW'(1)));

  fast_square_strobe_counter #(
    .CW (CW)
  ) u_strobe_counter (
    .clock   (clock),
    .reset_n (reset_n),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .len     (cnt_len),
    .term    (cnt_term)
  );

  // Next-state, step index and config latch; abort overrides everything.
  always_comb begin
    state_d      = state_q;
    step_d       = step_q;
    num_steps_d  = num_steps_q;
    settle_len_d = settle_len_q;
    record_len_d = record_len_q;
    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          num_steps_d  = num_steps;
          settle_len_d = settle_len;
          record_len_d = record_len;
          step_d       = '0;
          state_d      = (num_steps == '0) ? ST_DONE : ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if ((settle_len_q == '0) || cnt_term) begin
          state_d = ST_RECORD;
        end
      end
      ST_RECORD: begin
        if ((record_len_q == '0) || cnt_term) begin
          state_d = last_step ? ST_DONE : ST_STEP;
        end
      end
      ST_STEP: begin
        step_d  = step_q + SW'(1);
        state_d = ST_SETTLE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      step_d  = step_q;
    end
  end

  // Counter restarts on every phase change and stays cleared outside counting phases.
  always_comb begin
    cnt_clr = (state_d != state_q) || !in_count_state;
  end

  // State, step index and latched configuration registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      step_q       <= '0;
      num_steps_q  <= '0;
      settle_len_q <= '0;
      record_len_q <= '0;
    end else begin
      state_q      <= state_d;
      step_q       <= step_d;
      num_steps_q  <= num_steps_d;
      settle_len_q <= settle_len_d;
      record_len_q <= record_len_d;
    end
  end

  // Outputs decoded from state; abort kills the pulses in the same cycle.
  // A zero-length record window captures nothing, so record stays low.
  always_comb begin
    record       = (state_q == ST_RECORD) && !abort && (record_len_q != '0);
    freq_step    = (state_q == ST_STEP) && !abort;
    done         = (state_q == ST_DONE) && !abort;
    busy         = (state_q != ST_IDLE);
    sample_valid = record && strobe_in;
    step_index   = step_q;
  end

endmodule

// File: tb/tb_fast_square_sweep_ctrl.sv
// Directed testbench for fast_square_sweep_ctrl. Each task drives one scenario
// and compares outputs against hand-derived cycle numbers. Cycle k means the
// k-th clock period after the edge that accepts start (k=0 is the first busy
// cycle). Inputs change 1 ns after the rising edge, outputs are sampled on
// the falling edge.
module tb_fast_square_sweep_ctrl;

  localparam int SW = 8;
  localparam int CW = 16;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          start;
  logic          abort;
  logic          strobe_in;
  logic [SW-1:0] num_steps;
  logic [CW-1:0] settle_len;
  logic [CW-1:0] record_len;
  logic          freq_step;
  logic          record;
  logic          sample_valid;
  logic          busy;
  logic          done;
  logic [SW-1:0] step_index;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  fast_square_sweep_ctrl #(
    .SW (SW),
    .CW (CW)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .start        (start),
    .abort        (abort),
    .strobe_in    (strobe_in),
    .num_steps    (num_steps),
    .settle_len   (settle_len),
    .record_len   (record_len),
    .freq_step    (freq_step),
    .record       (record),
    .sample_valid (sample_valid),
    .busy         (busy),
    .done         (done),
    .step_index   (step_index)
  );

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  // Runs the 3-step / settle 2 / record 4 / strobe-every-17 sweep and reports
  // what it observed. With disturb set, start is re-pulsed while busy and the
  // config inputs are scrambled mid-sweep.
  task automatic run_profile(input bit disturb,
                             output int sv_cnt, output int sv_first,
                             output int fs_cnt, output int fs1, output int fs2,
                             output int done_cnt, output int done_cyc,
                             output int sidx_a, output int sidx_b,
                             output int busy_end);
    sv_cnt = 0; sv_first = -1; fs_cnt = 0; fs1 = -1; fs2 = -1;
    done_cnt = 0; done_cyc = -1; sidx_a = -1; sidx_b = -1; busy_end = -1;
    next_cycle();
    num_steps = 8'd3; settle_len = 16'd2; record_len = 16'd4;
    start = 1'b1; abort = 1'b0; strobe_in = 1'b0;
    for (int k = 0; k <= 320; k++) begin
      next_cycle();
      start     = 1'b0;
      strobe_in = ((k % 17) == 16);
      if (disturb) begin
        if (k == 40 || k == 150) start = 1'b1;
        if (k == 60) begin
          num_steps = 8'd1; settle_len = 16'd0; record_len = 16'd7;
        end
      end
      @(negedge clock);
      if (sample_valid) begin
        if (sv_cnt == 0) sv_first = k;
        sv_cnt++;
      end
      if (freq_step) begin
        fs_cnt++;
        if (fs_cnt == 1) fs1 = k; else fs2 = k;
      end
      if (done) begin
        done_cnt++;
        done_cyc = k;
      end
      if (k == 103) sidx_a = int'(step_index);
      if (k == 205) sidx_b = int'(step_index);
      if (k == 310) busy_end = int'(busy);
    end
    strobe_in = 1'b0;
  endtask

  task automatic check_profile(input string tag, input int sv_cnt, input int sv_first,
                               input int fs_cnt, input int fs1, input int fs2,
                               input int done_cnt, input int done_cyc,
                               input int sidx_a, input int sidx_b, input int busy_end);
    // Strobe n occurs in cycle 17n-1: settle ends on strobe 2 (cycle 33),
    // records strobes 3..6 (50..101), STEP at 102, and so on; DONE at 306.
    checks++; if (sv_cnt !== 12) begin errors++; $display("FAIL %s sample_valid count got %0d want 12", tag, sv_cnt); end
    checks++; if (sv_first !== 50) begin errors++; $display("FAIL %s first sample_valid cycle got %0d want 50", tag, sv_first); end
    checks++; if (fs_cnt !== 2) begin errors++; $display("FAIL %s freq_step count got %0d want 2", tag, fs_cnt); end
    checks++; if (fs1 !== 102) begin errors++; $display("FAIL %s first freq_step cycle got %0d want 102", tag, fs1); end
    checks++; if (fs2 !== 204) begin errors++; $display("FAIL %s second freq_step cycle got %0d want 204", tag, fs2); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL %s done count got %0d want 1", tag, done_cnt); end
    checks++; if (done_cyc !== 306) begin errors++; $display("FAIL %s done cycle got %0d want 306", tag, done_cyc); end
    checks++; if (sidx_a !== 1) begin errors++; $display("FAIL %s step_index at 103 got %0d want 1", tag, sidx_a); end
    checks++; if (sidx_b !== 2) begin errors++; $display("FAIL %s step_index at 205 got %0d want 2", tag, sidx_b); end
    checks++; if (busy_end !== 0) begin errors++; $display("FAIL %s busy after sweep got %0d want 0", tag, busy_end); end
    $display("%s: sv=%0d fs=%0d@%0d,%0d done=%0d@%0d", tag, sv_cnt, fs_cnt, fs1, fs2, done_cnt, done_cyc);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; strobe_in = 1'b1;
    num_steps = '0; settle_len = '0; record_len = '0;
    #2;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset done got %b want 0", done); end
    checks++; if (record !== 1'b0) begin errors++; $display("FAIL reset record got %b want 0", record); end
    checks++; if (freq_step !== 1'b0) begin errors++; $display("FAIL reset freq_step got %b want 0", freq_step); end
    checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL reset sample_valid got %b want 0", sample_valid); end
    checks++; if (step_index !== 8'd0) begin errors++; $display("FAIL reset step_index got %0d want 0", step_index); end
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1; strobe_in = 1'b0;
    next_cycle();
    @(negedge clock);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset idle after release busy got %b want 0", busy); end
    $display("test_reset done");
  endtask

  task automatic test_sweep_basic();
    int a, b, c, d, e, f, g, h, i, j;
    run_profile(1'b0, a, b, c, d, e, f, g, h, i, j);
    check_profile("basic", a, b, c, d, e, f, g, h, i, j);
  endtask

  task automatic test_midsweep_changes();
    int a, b, c, d, e, f, g, h, i, j;
    run_profile(1'b1, a, b, c, d, e, f, g, h, i, j);
    check_profile("disturbed", a, b, c, d, e, f, g, h, i, j);
  endtask

  task automatic test_zero_steps();
    next_cycle();
    num_steps = 8'd0; settle_len = 16'd5; record_len = 16'd5;
    start = 1'b1; strobe_in = 1'b1;
    next_cycle();
    start = 1'b0;
    @(negedge clock);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_steps done got %b want 1", done); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL zero_steps busy got %b want 1", busy); end
    checks++; if (record !== 1'b0) begin errors++; $display("FAIL zero_steps record got %b want 0", record); end
    checks++; if (freq_step !== 1'b0) begin errors++; $display("FAIL zero_steps freq_step got %b want 0", freq_step); end
    next_cycle();
    @(negedge clock);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL zero_steps done after got %b want 0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_steps busy after got %b want 0", busy); end
    strobe_in = 1'b0;
    $display("test_zero_steps done");
  endtask

  // settle 0 / record 0 / 2 steps, strobe held high: SETTLE(0) RECORD(1)
  // STEP(2) SETTLE(3) RECORD(4) DONE(5) IDLE(6).
  task automatic test_zero_lengths();
    next_cycle();
    num_steps = 8'd2; settle_len = 16'd0; record_len = 16'd0;
    start = 1'b1; strobe_in = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      next_cycle();
      start = 1'b0;
      @(negedge clock);
      checks++; if (freq_step !== (k == 2)) begin errors++; $display("FAIL zero_len freq_step k=%0d got %b want %b", k, freq_step, (k == 2)); end
      checks++; if (done !== (k == 5)) begin errors++; $display("FAIL zero_len done k=%0d got %b want %b", k, done, (k == 5)); end
      checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL zero_len sample_valid k=%0d got %b want 0", k, sample_valid); end
      checks++; if (busy !== (k <= 5)) begin errors++; $display("FAIL zero_len busy k=%0d got %b want %b", k, busy, (k <= 5)); end
      checks++; if (step_index !== ((k <= 2) ? 8'd0 : 8'd1)) begin errors++; $display("FAIL zero_len step_index k=%0d got %0d want %0d", k, step_index, (k <= 2) ? 0 : 1); end
    end
    strobe_in = 1'b0;
    $display("test_zero_lengths done");
  endtask

  // 3 steps, settle 1, record 3, strobe always high: RECORD in 1..3 and 6..8,
  // STEP at 4. abort raised in cycle 7, new start driven in cycle 8.
  task automatic test_abort();
    logic exp_rec;
    next_cycle();
    num_steps = 8'd3; settle_len = 16'd1; record_len = 16'd3;
    start = 1'b1; abort = 1'b0; strobe_in = 1'b1;
    for (int k = 0; k <= 7; k++) begin
      next_cycle();
      start = 1'b0;
      abort = (k == 7);
      @(negedge clock);
      exp_rec = (k >= 1 && k <= 3) || (k == 6);
      checks++; if (record !== exp_rec) begin errors++; $display("FAIL abort record k=%0d got %b want %b", k, record, exp_rec); end
      checks++; if (sample_valid !== exp_rec) begin errors++; $display("FAIL abort sample_valid k=%0d got %b want %b", k, sample_valid, exp_rec); end
      checks++; if (freq_step !== (k == 4)) begin errors++; $display("FAIL abort freq_step k=%0d got %b want %b", k, freq_step, (k == 4)); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort busy k=%0d got %b want 1", k, busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort done k=%0d got %b want 0", k, done); end
    end
    next_cycle();
    abort = 1'b0; start = 1'b1;
    @(negedge clock);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort idle busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort idle done got %b want 0", done); end
    next_cycle();
    start = 1'b0;
    @(negedge clock);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort restart busy got %b want 1", busy); end
    checks++; if (step_index !== 8'd0) begin errors++; $display("FAIL abort restart step_index got %0d want 0", step_index); end
    next_cycle();
    abort = 1'b1;
    next_cycle();
    abort = 1'b0;
    @(negedge clock);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort cleanup busy got %b want 0", busy); end
    strobe_in = 1'b0;
    $display("test_abort done");
  endtask

  task automatic test_start_abort_idle();
    next_cycle();
    num_steps = 8'd2; settle_len = 16'd3; record_len = 16'd3;
    start = 1'b1; abort = 1'b1;
    next_cycle();
    start = 1'b0; abort = 1'b0;
    @(negedge clock);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_abort busy got %b want 0", busy); end
    $display("test_start_abort_idle done");
  endtask

  // settle 0 / record 0 / 3 steps: cycle 3 is the SETTLE of step 1.
  task automatic test_async_reset();
    next_cycle();
    num_steps = 8'd3; settle_len = 16'd0; record_len = 16'd0;
    start = 1'b1; strobe_in = 1'b0;
    for (int k = 0; k <= 3; k++) begin
      next_cycle();
      start = 1'b0;
    end
    #2;
    checks++; if (step_index !== 8'd1) begin errors++; $display("FAIL async_reset pre step_index got %0d want 1", step_index); end
    reset_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL async_reset busy got %b want 0", busy); end
    checks++; if (step_index !== 8'd0) begin errors++; $display("FAIL async_reset step_index got %0d want 0", step_index); end
    checks++; if ((record | freq_step | done | sample_valid) !== 1'b0) begin errors++; $display("FAIL async_reset pulses got %b%b%b%b want 0000", record, freq_step, done, sample_valid); end
    @(negedge clock);
    reset_n = 1'b1;
    num_steps = 8'd0; start = 1'b1;
    next_cycle();
    start = 1'b0;
    @(negedge clock);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL async_reset first start done got %b want 1", done); end
    next_cycle();
    $display("test_async_reset done");
  endtask

  initial begin
    test_reset();
    test_sweep_basic();
    test_midsweep_changes();
    test_zero_steps();
    test_zero_lengths();
    test_abort();
    test_start_abort_idle();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
